// File: rtl/aes_enc_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_enc_round_ctrl
// Iterative control and state-register stage for AES-128 encryption.
// It drives the select of the external 3:1 round-input mux, registers the
// selected round result as the AES state, counts NR rounds, and presents the
// ciphertext on a valid/ready handshake.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    begin encryption (sampled only while in_ready=1)
//   in_ready   out  1    idle and able to accept start
//   mux_out_i  in   128  round result selected by the external 3:1 mux
//   sel        out  2    mux select: 00 initial ARK, 01 middle, 10 final
//   round      out  4    current round index for key schedule / round logic
//   state_q    out  128  registered AES state
//   busy       out  1    encryption in progress (until ciphertext accepted)
//   ct         out  128  ciphertext
//   ct_valid   out  1    ciphertext valid
//   ct_ready   in   1    downstream accepts ciphertext
// ---------------------------------------------------------------------------
module aes_enc_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [127:0] mux_out_i,
  output logic [1:0]   sel,
  output logic [3:0]   round,
  output logic [127:0] state_q,
  output logic         busy,
  output logic [127:0] ct,
  output logic         ct_valid,
  input  logic         ct_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Round index at which the last middle round is loaded; the edge that
  // loads it also advances the counter to NR and enters FINAL.
  localparam logic [3:0] LAST_MID = 4'(NR - 1);

  state_e       state_r;
  state_e       state_nxt_s;
  logic [127:0] state_q_r;
  logic [127:0] state_q_nxt_s;
  logic [127:0] ct_r;
  logic [127:0] ct_nxt_s;
  logic [3:0]   round_r;
  logic [3:0]   round_nxt_s;
  logic         ct_valid_r;
  logic         ct_valid_nxt_s;
  logic [1:0]   sel_s;

  // State and datapath registers; reset clears everything, no partial result survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      state_q_r  <= 128'd0;
      ct_r       <= 128'd0;
      round_r    <= 4'd0;
      ct_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      state_q_r  <= state_q_nxt_s;
      ct_r       <= ct_nxt_s;
      round_r    <= round_nxt_s;
      ct_valid_r <= ct_valid_nxt_s;
    end
  end

  // Next-state and next-register values; every register holds unless a state acts on it.
  always_comb begin
    state_nxt_s    = state_r;
    state_q_nxt_s  = state_q_r;
    ct_nxt_s       = ct_r;
    round_nxt_s    = round_r;
    ct_valid_nxt_s = ct_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // mux is on sel=00 here, so this loads the initial AddRoundKey result
          state_q_nxt_s = mux_out_i;
          round_nxt_s   = 4'd1;
          state_nxt_s   = ST_ROUND;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_ROUND: begin
        state_q_nxt_s = mux_out_i;
        round_nxt_s   = round_r + 4'd1;
        if (round_r == LAST_MID) begin
          state_nxt_s = ST_FINAL;
        end else begin
          state_nxt_s = ST_ROUND;
        end
      end
      ST_FINAL: begin
        // final-round result goes to ct only; state_q keeps the last middle state
        ct_nxt_s       = mux_out_i;
        ct_valid_nxt_s = 1'b1;
        state_nxt_s    = ST_HOLD;
      end
      ST_HOLD: begin
        if (ct_ready) begin
          ct_valid_nxt_s = 1'b0;
          round_nxt_s    = 4'd0;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s    = ST_HOLD;
        end
      end
      default: begin
        ct_valid_nxt_s = 1'b0;
        round_nxt_s    = 4'd0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  // Mux select decode; code 11 is never produced.
  always_comb begin
    sel_s = 2'b00;
    case (state_r)
      ST_IDLE:  sel_s = 2'b00;
      ST_ROUND: sel_s = 2'b01;
      ST_FINAL: sel_s = 2'b10;
      ST_HOLD:  sel_s = 2'b00;
      default:  sel_s = 2'b00;
    endcase
  end

  // The FSM already sits in IDLE during reset, so in_ready is gated by
  // rst_n to keep the block from advertising readiness while held in reset.
  assign in_ready = rst_n & (state_r == ST_IDLE);
  assign busy     = (state_r != ST_IDLE);
  assign sel      = sel_s;
  assign round    = round_r;
  assign state_q  = state_q_r;
  assign ct       = ct_r;
  assign ct_valid = ct_valid_r;

endmodule

// File: doc/aes_enc_round_ctrl.md
Name: aes_enc_round_ctrl

Overview:
- Iterative control and state-register stage for AES-128 encryption. Sits around the 3:1 round-input mux.
- Drives the mux select (initial / middle / final round), registers the selected 128-bit result every cycle as the round state, and sequences NR rounds.
- Presents the ciphertext on a valid/ready output handshake. It also publishes the round number to the key schedule.

Parameters:
NR, 10, number of AES rounds (legal 2..14; 10 for AES-128)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin encryption; sampled only when in_ready=1
in_ready  output  1  high when idle and able to accept start
mux_out_i  input  128  selected round result returned from the 3:1 mux
sel  output  2  mux select: 00 initial AddRoundKey, 01 middle round, 10 final round
round  output  4  current round index to the key schedule and round logic
state_q  output  128  registered AES state, fed to the round logic
busy  output  1  high from start acceptance until ciphertext handshake completes
ct  output  128  ciphertext
ct_valid  output  1  ciphertext valid
ct_ready  input  1  downstream accepts ciphertext

Behaviour:
- Reset: rst_n=0 asynchronously forces the FSM to IDLE, state_q=0, ct=0, round=0, ct_valid=0, busy=0. While in reset, in_ready=0 and sel=00. This applies at any point, including mid-encryption; no partial result survives.
- FSM states: IDLE, ROUND, FINAL, HOLD.
- sel is decoded combinationally from the FSM state: IDLE→00, ROUND→01, FINAL→10, HOLD→00. Code 11 is never driven.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - round=0.
  - On an edge with start=1: state_q<=mux_out_i (initial AddRoundKey result), round<=1, go to ROUND.
  - On an edge with start=0: nothing changes.
- ROUND:
  - Every edge: state_q<=mux_out_i and round<=round+1.
  - If round==NR-1 at that edge, go to FINAL; otherwise stay in ROUND.
- FINAL (round==NR):
  - On the next edge: ct<=mux_out_i, ct_valid<=1, go to HOLD.
  - state_q is not updated in FINAL.
- HOLD:
  - ct and ct_valid are held stable while ct_ready=0.
  - On an edge with ct_ready=1: ct_valid<=0, round<=0, go to IDLE.
  - ct keeps its value until the next FINAL.
- Latency: start is sampled at edge E0 and ct_valid is high after edge E0+NR (11 loads for NR=10).
- Earliest restart: start is accepted again on the edge after the edge that completes the handshake. Throughput is therefore one block per NR+2 cycles when ct_ready is held high.
- start is ignored outside IDLE: no restart and no queueing.
- ct_ready outside HOLD has no effect.
- round never exceeds NR. The counter is 4 bits wide, which is sufficient for NR≤14.
- Width rule: mux_out_i is registered verbatim, with no arithmetic on the data path.

Test Plan:
- Reset values: assert rst_n=0, release, idle 5 cycles with start=0 → in_ready=1, busy=0, sel=00, round=0, state_q=0, ct_valid=0.
- Nominal NR=10 sequence: bench mux model returns 128'h{sel,round,…} per cycle; pulse start one cycle, hold ct_ready=1.
  - sel must read 00, then 01 ×9 with round 1..9, then 10 with round=10.
  - ct_valid must rise exactly 10 edges after start is sampled.
  - ct must equal the model value for sel=10, round=10.
  - in_ready must return one cycle later.
- Backpressure: hold ct_ready=0 for 7 cycles after ct_valid rises → ct and ct_valid stay stable, start pulses are ignored, busy=1. Release ct_ready → ct_valid drops after one edge.
- Start ignored mid-run: pulse start at round=4 → the sequence is unaltered and the total latency is still 10.
- Async reset mid-operation: drop rst_n at round=6, between clock edges → outputs clear immediately with no clock. After release, a new start produces a full correct 10-round sequence.
- Parameter sweep NR=14 using the FIPS-197 AES-256 round count → exactly 13 sel=01 cycles, final round=14, and ct_valid 14 edges after start.
